mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter MUX_LAT, default 4, giving the cycles sel must be held stable before mux_dout is valid (legal range 1..15).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  single-cycle request to begin a scan.
REQ-006 The block SHALL have port start_idx  input  6  first lane index of the scan.
REQ-007 The block SHALL have port count  input  7  number of lanes to scan.
REQ-008 The block SHALL have port sel  output  6  lane select driven to the downstream 64:1 byte mux.
REQ-009 The block SHALL have port mux_dout  input  8  byte returned by the mux.
REQ-010 The block SHALL have port out_data  output  8  captured byte at the FIFO head.
REQ-011 The block SHALL have port out_idx  output  6  lane index of out_data.
REQ-012 The block SHALL have port out_valid  output  1  FIFO head is valid.
REQ-013 The block SHALL have port out_ready  input  1  consumer accepts the head.
REQ-014 The block SHALL have port busy  output  1  a scan is in progress.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse when the last lane of a scan is written into the FIFO.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE and CAPTURE; busy SHALL be 1 in SETTLE and CAPTURE and 0 in IDLE.
REQ-017 In IDLE, start=1 with count!=0 SHALL load cur_idx=start_idx, set remaining=min(count,64), drive sel=start_idx and enter SETTLE on the next edge.
REQ-018 start with count=0 SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-019 sel SHALL equal cur_idx and SHALL NOT change while in SETTLE or CAPTURE for the current lane.
REQ-020 SETTLE SHALL last exactly MUX_LAT cycles, counted by a settle counter cleared on entry, then go to CAPTURE.
REQ-021 In CAPTURE, if the FIFO is not full, the block SHALL write {mux_dout, cur_idx} into the FIFO in that cycle.
REQ-022 In CAPTURE with the FIFO full, the block SHALL stay in CAPTURE with sel held and write nothing until a slot frees.
REQ-023 A CAPTURE write with remaining>1 SHALL decrement remaining, set cur_idx=(cur_idx+1) mod 64 and go to SETTLE.
REQ-024 Index 63 SHALL wrap to 0.
REQ-025 A CAPTURE write with remaining=1 SHALL assert done for that one cycle and return to IDLE.
REQ-026 A lane SHALL therefore take exactly MUX_LAT+1 cycles when not stalled; a 64-lane scan SHALL take 64*(MUX_LAT+1) cycles from the start edge to done.
REQ-027 The FIFO SHALL be first-word-fall-through: out_valid=1 whenever it is non-empty, with out_data/out_idx showing the oldest entry.
REQ-028 A pop SHALL occur on out_valid & out_ready.
REQ-029 A simultaneous push and pop when full SHALL be allowed: the pop frees the slot in the same cycle, the CAPTURE write proceeds, and occupancy is unchanged.
REQ-030 A simultaneous push and pop when empty SHALL not bypass: out_valid rises the cycle after the push.
REQ-031 out_data and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 FIFO contents SHALL remain drainable after the scan returns to IDLE; a new scan MAY start while the FIFO is non-empty.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, sel=0, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, the FIFO empty and all counters 0.
REQ-034 Reset asserted mid-scan SHALL abandon the scan and discard FIFO contents; after release the block SHALL sit in IDLE until the next start.

Verification
REQ-035 Scenario: MUX_LAT=4, start_idx=5, count=3, out_ready=1 -> sel=5,6,7 for 5 cycles each; out_idx 5,6,7 with the matching mux bytes; done pulses at cycle 15 after start.
REQ-036 Scenario: start_idx=62, count=4 -> captured indices 62,63,0,1; done once.
REQ-037 Scenario: out_ready=0, count=6, FIFO_DEPTH=4 -> 4 entries stored, the FSM stalls in CAPTURE with sel=start_idx+4; raising out_ready completes the remaining two lanes in order.
REQ-038 Scenario: count=0 start, then start while busy -> no state change in either case.
REQ-039 Scenario: count=100 -> exactly 64 entries captured, covering every index once.
REQ-040 Scenario: rst_n low for 1 cycle mid-scan with FIFO occupancy 2 -> out_valid=0 and busy=0 asynchronously; no stale entries appear after release.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the scan sequencer, its requester, the downstream lane mux
// and the capture consumer.
interface mux_scan_sequencer_if;
  logic       start;
  logic [5:0] start_idx;
  logic [6:0] count;
  logic [5:0] sel;
  logic [7:0] mux_dout;
  logic [7:0] out_data;
  logic [5:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    output start, start_idx, count, mux_dout, out_ready,
    input  sel, out_data, out_idx, out_valid, busy, done
  );

  modport slave (
    input  start, start_idx, count, mux_dout, out_ready,
    output sel, out_data, out_idx, out_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks a range of lanes through an external 64:1 byte mux, waits MUX_LAT cycles per lane,
// then queues {byte, lane} into a first-word-fall-through output FIFO.
module mux_scan_sequencer #(
  parameter int unsigned MUX_LAT    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_scan_sequencer_if.slave bus
);
  localparam int unsigned Aw = $clog2(FIFO_DEPTH);
  typedef logic [Aw:0] occ_t;
  localparam occ_t       FullOcc    = occ_t'(FIFO_DEPTH);
  localparam logic [3:0] SettleLast = 4'(MUX_LAT - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

  state_e        state_q, state_d;
  logic [5:0]    cur_idx_q, cur_idx_d;
  logic [6:0]    remaining_q, remaining_d;
  logic [3:0]    settle_cnt_q, settle_cnt_d;

  logic [13:0]   mem_q [FIFO_DEPTH];
  logic [Aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0] rd_ptr_q, rd_ptr_d;
  occ_t          occ_q, occ_d;

  logic          fifo_valid, fifo_full, push, pop, can_push, done;

  assign fifo_valid = (occ_q != '0);
  assign fifo_full  = (occ_q == FullOcc);
  assign pop        = fifo_valid & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
  assign can_push   = ~fifo_full | pop;

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    remaining_d  = remaining_q;
    settle_cnt_d = settle_cnt_q;
    push         = 1'b0;
    done         = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start && (bus.count != 7'd0)) begin
          cur_idx_d    = bus.start_idx;
          remaining_d  = (bus.count > 7'd64) ? 7'd64 : bus.count;
          settle_cnt_d = 4'd0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StCapture;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StCapture: begin
        if (can_push) begin
          push = 1'b1;
          if (remaining_q == 7'd1) begin
            done        = 1'b1;
            remaining_d = 7'd0;
            state_d     = StIdle;
          end else begin
            remaining_d  = remaining_q - 7'd1;
            cur_idx_d    = cur_idx_q + 6'd1;
            settle_cnt_d = 4'd0;
            state_d      = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cur_idx_q    <= 6'd0;
      remaining_q  <= 7'd0;
      settle_cnt_q <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      remaining_q  <= remaining_d;
      settle_cnt_q <= settle_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.mux_dout, cur_idx_q};
  end

  // Head is masked while empty so reset shows zeros without clearing the storage.
  assign {bus.out_data, bus.out_idx} = fifo_valid ? mem_q[rd_ptr_q] : 14'd0;
  assign bus.out_valid = fifo_valid;
  assign bus.sel       = cur_idx_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a latency-aware mux model, an expected-entry queue
// checked at every falling edge, and literal timing checks for the key scenarios.
module tb_mux_scan_sequencer;
  localparam int unsigned MuxLat = 4;

  logic clk = 1'b0;
  logic rst_n;

  mux_scan_sequencer_if bus ();

  mux_scan_sequencer #(
    .MUX_LAT   (MuxLat),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          popped = 0;
  logic [63:0] seen = '0;
  logic [13:0] exp_q[$];

  function automatic logic [7:0] lane_byte(input logic [5:0] s);
    return 8'(s) * 8'd3 + 8'h41;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Mux returns garbage until sel has been steady for MuxLat full cycles.
  logic [5:0]  last_sel = 6'd0;
  int unsigned age = 0;
  always @(negedge clk) begin
    if (bus.sel != last_sel) begin
      last_sel = bus.sel;
      age      = 0;
    end else if (age < 1000) begin
      age++;
    end
    bus.mux_dout = (age >= MuxLat) ? lane_byte(bus.sel) : 8'hEE;
  end

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (bus.out_valid) begin
        chk("unexpected_entry", 32'(bus.out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) begin
          chk("fifo_head", 32'({bus.out_data, bus.out_idx}), 32'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            seen[bus.out_idx] = 1'b1;
            popped++;
          end
        end
      end
      if (bus.done) done_cnt++;
    end
  endtask

  task automatic start_scan(input logic [5:0] idx, input logic [6:0] cnt, input bit accept);
    int n;
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.start_idx = idx;
    bus.count     = cnt;
    if (accept) begin
      n = (cnt > 7'd64) ? 64 : int'(cnt);
      for (int k = 0; k < n; k++) begin
        logic [5:0] li;
        li = 6'(int'(idx) + k);
        exp_q.push_back({lane_byte(li), li});
      end
    end
    tick();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.out_ready = r;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.start_idx = 6'd0;
    bus.count     = 7'd0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // Three lanes from 5: five cycles per lane, done on the 15th edge after start.
    d0 = done_cnt;
    start_scan(6'd5, 7'd3, 1'b1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("s1_sel_%0d", k), 32'(bus.sel), 32'(5 + k / 5));
      chk($sformatf("s1_busy_%0d", k), 32'(bus.busy), 32'd1);
      chk($sformatf("s1_done_%0d", k), 32'(bus.done), (k == 14) ? 32'd1 : 32'd0);
      chk($sformatf("s1_valid_%0d", k), 32'(bus.out_valid), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      if (k == 5) begin
        chk("s1_first_data", 32'(bus.out_data), 32'h50);
        chk("s1_first_idx", 32'(bus.out_idx), 32'd5);
      end
    end
    tick();
    chk("s1_idle", 32'(bus.busy), 32'd0);
    chk("s1_last_idx", 32'(bus.out_idx), 32'd7);
    chk("s1_last_data", 32'(bus.out_data), 32'h56);
    drain("s1_drain", 10);
    chk("s1_done_once", 32'(done_cnt - d0), 32'd1);

    // Wrap from 63 to 0.
    d0 = done_cnt;
    start_scan(6'd62, 7'd4, 1'b1);
    wait_idle("s2_idle", 40);
    drain("s2_drain", 10);
    chk("s2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("s2_sel_end", 32'(bus.sel), 32'd1);

    // Consumer stalled: four entries fill the FIFO and the fifth lane waits in capture.
    d0 = done_cnt;
    set_ready(1'b0);
    start_scan(6'd20, 7'd6, 1'b1);
    for (int k = 0; k < 30; k++) tick();
    chk("s3_stall_sel", 32'(bus.sel), 32'd24);
    chk("s3_stall_busy", 32'(bus.busy), 32'd1);
    chk("s3_stall_valid", 32'(bus.out_valid), 32'd1);
    chk("s3_stall_head", 32'(bus.out_idx), 32'd20);
    chk("s3_no_done", 32'(done_cnt - d0), 32'd0);
    set_ready(1'b1);
    wait_idle("s3_idle", 60);
    drain("s3_drain", 20);
    chk("s3_done_once", 32'(done_cnt - d0), 32'd1);

    // Zero-count start and start-while-busy are both ignored.
    start_scan(6'd3, 7'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("s4_zero_busy_%0d", k), 32'(bus.busy), 32'd0);
    end
    chk("s4_zero_sel", 32'(bus.sel), 32'd25);
    d0 = done_cnt;
    start_scan(6'd30, 7'd2, 1'b1);
    tick();
    start_scan(6'd40, 7'd3, 1'b0);
    wait_idle("s4_idle", 40);
    drain("s4_drain", 10);
    for (int k = 0; k < 10; k++) tick();
    chk("s4_still_idle", 32'(bus.busy), 32'd0);
    chk("s4_sel_end", 32'(bus.sel), 32'd31);
    chk("s4_done_once", 32'(done_cnt - d0), 32'd1);

    // Count above 64 saturates to a full sweep.
    d0     = done_cnt;
    seen   = '0;
    popped = 0;
    start_scan(6'd7, 7'd100, 1'b1);
    wait_idle("s5_idle", 64 * (MuxLat + 1) + 20);
    drain("s5_drain", 10);
    for (int k = 0; k < 10; k++) tick();
    chk("s5_entries", 32'(popped), 32'd64);
    chk("s5_all_lanes", 32'($countones(seen)), 32'd64);
    chk("s5_done_once", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset mid-scan with two entries held.
    d0 = done_cnt;
    set_ready(1'b0);
    start_scan(6'd10, 7'd5, 1'b1);
    for (int k = 0; k < 12; k++) tick();
    chk("s6_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("s6_pre_head", 32'(bus.out_idx), 32'd10);
    chk("s6_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_async_busy", 32'(bus.busy), 32'd0);
    chk("s6_async_sel", 32'(bus.sel), 32'd0);
    chk("s6_async_data", 32'(bus.out_data), 32'd0);
    chk("s6_async_idx", 32'(bus.out_idx), 32'd0);
    chk("s6_async_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("s6_post_busy", 32'(bus.busy), 32'd0);
    chk("s6_post_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_post_sel", 32'(bus.sel), 32'd0);
    chk("s6_no_done", 32'(done_cnt - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
